usb_fs_tx_arb: RTL and testbench
================================

// Module: usb_fs_tx_arb
// PURPOSE
//  Arbitrates and sequences the full-speed transmitter between two requesters:
//  the handshake path (ACK/NAK/STALL, no payload) and the IN-data path (DATA0/1
//  with a byte stream). It grants one requester, issues the single-cycle
//  packet-start pulse and PID to usb_fs_tx, and muxes the byte pull handshake.
//  After the packet ends, it enforces an inter-packet gap and signals completion.
// PARAMETERS
//  GapCycles      8      clk cycles after tx_pkt_end_i before next grant (>=1)
//  TimeoutCycles  4096   clk cycles in Active without tx_pkt_end_i -> abort
// PORTS
//  clk_i            in   1  48 MHz clock
//  rst_ni           in   1  async reset, active low
//  link_reset_i     in   1  USB bus reset, sync, active high; acts as sync clear
//  hs_req_i         in   1  handshake request, level, held until hs_done_o
//  hs_pid_i         in   4  handshake PID, stable while hs_req_i
//  hs_done_o        out  1  1-cycle pulse: handshake packet fully sent
//  in_req_i         in   1  IN-data request, level, held until in_done_o
//  in_pid_i         in   4  DATA PID, stable while in_req_i
//  in_data_avail_i  in   1  IN byte available
//  in_data_i        in   8  IN byte
//  in_data_get_o    out  1  IN byte consumed (pass-through of tx_data_get_i)
//  in_done_o        out  1  1-cycle pulse: IN packet fully sent
//  tx_pkt_start_o   out  1  1-cycle packet-start pulse to transmitter
//  tx_pid_o         out  4  PID to transmitter, valid with tx_pkt_start_o
//  tx_data_avail_o  out  1  byte available to transmitter
//  tx_data_o        out  8  byte to transmitter
//  tx_data_get_i    in   1  transmitter pulled a byte
//  tx_pkt_end_i     in   1  transmitter end-of-packet pulse
//  busy_o           out  1  state != Idle
//  timeout_o        out  1  1-cycle pulse: watchdog abort
// BEHAVIOUR
//  - Reset (async or link_reset_i): state=Idle, grant=None, all outputs 0,
//    tx_pid_o=0, counters 0. link_reset_i mid-packet aborts; no done pulse.
//  - FSM: Idle -> Start -> Active -> Gap -> Idle.
//    Idle: if hs_req_i, grant=Hs; else if in_req_i, grant=In. Handshake has
//      fixed priority. Latch the PID of the granted requester. Go to Start.
//    Start: tx_pkt_start_o=1 for exactly this cycle; tx_pid_o=latched PID.
//      Go to Active.
//    Active: wait for tx_pkt_end_i. Then pulse hs_done_o or in_done_o on the
//      next cycle, according to grant. Load the gap counter with GapCycles-1.
//      Go to Gap.
//    Gap: count down; at 0 go to Idle, clear grant. Requests are not sampled
//      in Gap.
//  - Latency: request rising in Idle -> tx_pkt_start_o 2 cycles later.
//    tx_pkt_end_i -> done pulse 1 cycle later. Done -> earliest next start:
//    GapCycles+2 cycles.
//  - tx_pid_o holds the latched PID from Start until the return to Idle.
//  - Data mux (combinational):
//    - grant=In: tx_data_avail_o=in_data_avail_i, tx_data_o=in_data_i,
//      in_data_get_o=tx_data_get_i.
//    - Otherwise: tx_data_avail_o=0, tx_data_o=0, in_data_get_o=0.
//  - Watchdog: counter cleared in Start and incremented in Active. On reaching
//    TimeoutCycles-1 without tx_pkt_end_i: pulse timeout_o, emit no done
//    pulse, go to Gap.
//  - Simultaneous events:
//    - hs_req_i & in_req_i in Idle: Hs wins; In stays pending and is served
//      after the Gap.
//    - tx_pkt_end_i in the same cycle as the timeout: end wins, done is pulsed.
//  - A request dropped before its done is a protocol violation (assertion).
//    The packet still completes.
//  - The counter is sized $clog2(max(GapCycles, TimeoutCycles)) bits.
//  - Assertions:
//    - state valid;
//    - tx_pkt_start_o onehot-in-time with Start;
//    - never hs_done_o & in_done_o.
// STRUCTURE
//  - usbdev_pkg: the arb_state_e {Idle, Start, Active, Gap} and
//    arb_grant_e {GrantNone, GrantHs, GrantIn} typedefs.
//  - usbdev_pkg: the USB PID localparams (ACK, NAK, STALL, DATA0, DATA1).
//  - A single module; no sub-module. One shared down/up counter serves both
//    Gap and the watchdog.
// TESTING
//  1 hs_req_i=1, hs_pid_i=4'b0010 (ACK) -> tx_pkt_start_o 1 cycle, tx_pid_o=2,
//    tx_data_avail_o=0. tx_pkt_end_i -> hs_done_o next cycle. busy_o=0 after
//    GapCycles.
//  2 in_req_i=1, in_pid_i=4'b0011, 3 bytes 0xA5,0x5A,0xFF -> tx_data_o
//    follows in_data_i. Exactly 3 in_data_get_o pulses. in_done_o after
//    tx_pkt_end_i.
//  3 hs_req_i and in_req_i raised the same cycle -> handshake start first,
//    then DATA start exactly GapCycles+2 cycles after hs_done_o.
//  4 No tx_pkt_end_i for TimeoutCycles in Active -> timeout_o pulse, no done
//    pulse, return to Idle after the gap.
//  5 link_reset_i asserted in Active during a byte pull -> next cycle Idle,
//    all outputs 0, no done pulse. A new request after release is served
//    normally.
//  6 rst_ni asserted asynchronously mid-Gap -> outputs 0 immediately,
//    tx_pid_o=0. Recovery on the first request after release.

Source files
------------

// File: rtl/usbdev_pkg.sv
// Shared types and USB PID constants for the full-speed transmit arbiter.
package usbdev_pkg;

   typedef enum logic [1:0] {Idle, Start, Active, Gap} arb_state_e;
   typedef enum logic [1:0] {GrantNone, GrantHs, GrantIn} arb_grant_e;

   localparam logic [3:0] PidAck   = 4'b0010;
   localparam logic [3:0] PidNak   = 4'b1010;
   localparam logic [3:0] PidStall = 4'b1110;
   localparam logic [3:0] PidData0 = 4'b0011;
   localparam logic [3:0] PidData1 = 4'b1011;

endpackage

// File: rtl/usb_fs_tx_arb.sv
// Grants the full-speed transmitter to the handshake or IN-data path, sequences
// start/active/gap and muxes the byte-pull handshake of the granted requester.
module usb_fs_tx_arb
   import usbdev_pkg::*;
#(
   parameter int unsigned GapCycles     = 8,
   parameter int unsigned TimeoutCycles = 4096
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       link_reset_i,
   input  logic       hs_req_i,
   input  logic [3:0] hs_pid_i,
   output logic       hs_done_o,
   input  logic       in_req_i,
   input  logic [3:0] in_pid_i,
   input  logic       in_data_avail_i,
   input  logic [7:0] in_data_i,
   output logic       in_data_get_o,
   output logic       in_done_o,
   output logic       tx_pkt_start_o,
   output logic [3:0] tx_pid_o,
   output logic       tx_data_avail_o,
   output logic [7:0] tx_data_o,
   input  logic       tx_data_get_i,
   input  logic       tx_pkt_end_i,
   output logic       busy_o,
   output logic       timeout_o
);

   localparam int unsigned CntMax = (GapCycles > TimeoutCycles) ? GapCycles : TimeoutCycles;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam logic [CntW-1:0] GapLoad = CntW'(GapCycles - 1);
   localparam logic [CntW-1:0] ToLast  = CntW'(TimeoutCycles - 1);

   arb_state_e       r_state;
   arb_grant_e       r_grant;
   logic [CntW-1:0]  r_cnt;
   logic [3:0]       r_pid;
   logic             r_hs_req, r_in_req;
   logic             r_start, r_hs_done, r_in_done, r_timeout;
   logic             w_grant_in;

   // Requests are registered only while Idle, so a request pending through
   // the gap is seen one cycle after the return to Idle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= Idle;
         r_grant   <= GrantNone;
         r_cnt     <= '0;
         r_pid     <= '0;
         r_hs_req  <= 1'b0;
         r_in_req  <= 1'b0;
         r_start   <= 1'b0;
         r_hs_done <= 1'b0;
         r_in_done <= 1'b0;
         r_timeout <= 1'b0;
      end else if (link_reset_i) begin
         r_state   <= Idle;
         r_grant   <= GrantNone;
         r_cnt     <= '0;
         r_pid     <= '0;
         r_hs_req  <= 1'b0;
         r_in_req  <= 1'b0;
         r_start   <= 1'b0;
         r_hs_done <= 1'b0;
         r_in_done <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_start   <= 1'b0;
         r_hs_done <= 1'b0;
         r_in_done <= 1'b0;
         r_timeout <= 1'b0;
         unique case (r_state)
            Idle: begin
               if (r_hs_req) begin
                  r_grant  <= GrantHs;
                  r_pid    <= hs_pid_i;
                  r_start  <= 1'b1;
                  r_hs_req <= 1'b0;
                  r_in_req <= 1'b0;
                  r_state  <= Start;
               end else if (r_in_req) begin
                  r_grant  <= GrantIn;
                  r_pid    <= in_pid_i;
                  r_start  <= 1'b1;
                  r_in_req <= 1'b0;
                  r_state  <= Start;
               end else begin
                  r_hs_req <= hs_req_i;
                  r_in_req <= in_req_i;
               end
            end
            Start: begin
               r_cnt   <= '0;
               r_state <= Active;
            end
            Active: begin
               // End beats a coincident watchdog expiry.
               if (tx_pkt_end_i) begin
                  r_hs_done <= (r_grant == GrantHs);
                  r_in_done <= (r_grant == GrantIn);
                  r_cnt     <= GapLoad;
                  r_state   <= Gap;
               end else if (r_cnt == ToLast) begin
                  r_timeout <= 1'b1;
                  r_cnt     <= GapLoad;
                  r_state   <= Gap;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            Gap: begin
               if (r_cnt == '0) begin
                  r_state <= Idle;
                  r_grant <= GrantNone;
                  r_pid   <= '0;
               end else begin
                  r_cnt <= r_cnt - CntW'(1);
               end
            end
            default: r_state <= Idle;
         endcase
      end
   end

   assign w_grant_in = (r_grant == GrantIn);

   always_comb begin
      tx_data_avail_o = 1'b0;
      tx_data_o       = '0;
      in_data_get_o   = 1'b0;
      if (w_grant_in) begin
         tx_data_avail_o = in_data_avail_i;
         tx_data_o       = in_data_i;
         in_data_get_o   = tx_data_get_i;
      end
   end

   assign tx_pkt_start_o = r_start;
   assign tx_pid_o       = r_pid;
   assign hs_done_o      = r_hs_done;
   assign in_done_o      = r_in_done;
   assign timeout_o      = r_timeout;
   assign busy_o         = (r_state != Idle);

`ifndef SYNTHESIS
   a_state_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_state inside {Idle, Start, Active, Gap});
   a_start_with_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
      tx_pkt_start_o == (r_state == Start));
   a_done_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(hs_done_o && in_done_o));
   a_hs_held: assert property (@(posedge clk_i) disable iff (!rst_ni || link_reset_i)
      (r_grant == GrantHs && r_state inside {Start, Active}) |-> hs_req_i);
   a_in_held: assert property (@(posedge clk_i) disable iff (!rst_ni || link_reset_i)
      (r_grant == GrantIn && r_state inside {Start, Active}) |-> in_req_i);
`endif

endmodule

// File: tb/tb_usb_fs_tx_arb.sv
// Directed-random bench for usb_fs_tx_arb; expected event cycles come from the
// latency rules (start = req+2, done = end+1, idle = done+G, timeout = start+T+1).
module tb_usb_fs_tx_arb;
   import usbdev_pkg::*;

   localparam int unsigned G = 8;
   localparam int unsigned T = 64;

   logic       clk_i = 1'b0, rst_ni = 1'b0, link_reset_i = 1'b0;
   logic       hs_req_i = 1'b0, in_req_i = 1'b0, in_data_avail_i = 1'b0;
   logic       tx_data_get_i = 1'b0, tx_pkt_end_i = 1'b0;
   logic [3:0] hs_pid_i = '0, in_pid_i = '0;
   logic [7:0] in_data_i = '0;
   logic       hs_done_o, in_data_get_o, in_done_o, tx_pkt_start_o;
   logic       tx_data_avail_o, busy_o, timeout_o;
   logic [3:0] tx_pid_o;
   logic [7:0] tx_data_o;

   int checks = 0, errors = 0, cyc = 0, get_cnt = 0;
   int start_q[$], hs_done_q[$], in_done_q[$], to_q[$];
   logic [3:0] pid_q[$];
   logic [3:0] hs_pids[3] = '{PidAck, PidNak, PidStall};
   logic [3:0] in_pids[2] = '{PidData0, PidData1};
   logic [7:0] bytes[3]   = '{8'hA5, 8'h5A, 8'hFF};

   usb_fs_tx_arb #(.GapCycles(G), .TimeoutCycles(T)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .link_reset_i(link_reset_i),
      .hs_req_i(hs_req_i), .hs_pid_i(hs_pid_i), .hs_done_o(hs_done_o),
      .in_req_i(in_req_i), .in_pid_i(in_pid_i), .in_data_avail_i(in_data_avail_i),
      .in_data_i(in_data_i), .in_data_get_o(in_data_get_o), .in_done_o(in_done_o),
      .tx_pkt_start_o(tx_pkt_start_o), .tx_pid_o(tx_pid_o),
      .tx_data_avail_o(tx_data_avail_o), .tx_data_o(tx_data_o),
      .tx_data_get_i(tx_data_get_i), .tx_pkt_end_i(tx_pkt_end_i),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (tx_pkt_start_o) begin
            start_q.push_back(cyc);
            pid_q.push_back(tx_pid_o);
         end
         if (hs_done_o) hs_done_q.push_back(cyc);
         if (in_done_o) in_done_q.push_back(cyc);
         if (timeout_o) to_q.push_back(cyc);
         if (in_data_get_o) get_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_end(output int e);
      tx_pkt_end_i = 1'b1;
      e = cyc;
      tick();
      tx_pkt_end_i = 1'b0;
   endtask

   function automatic void clr();
      start_q.delete(); pid_q.delete(); hs_done_q.delete();
      in_done_q.delete(); to_q.delete(); get_cnt = 0;
   endfunction

   initial begin
      int c, e, k;
      logic [3:0] hp, ip;

      // Reset state
      #1;
      chk("rst_start", tx_pkt_start_o, 0);
      chk("rst_pid", tx_pid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", {hs_done_o, in_done_o, timeout_o}, 0);
      ticks(2);
      rst_ni = 1'b1;
      tick();

      // 1: ACK handshake; IN data offered but not granted must stay hidden
      clr();
      in_data_avail_i = 1'b1; in_data_i = 8'($urandom);
      hs_pid_i = PidAck; hs_req_i = 1'b1; c = cyc; k = $urandom_range(2, 12);
      ticks(2 + k);
      chk("t1_pid_hold", tx_pid_o, PidAck);
      chk("t1_avail_masked", tx_data_avail_o, 0);
      chk("t1_data_masked", tx_data_o, 0);
      pulse_end(e);
      chk("t1_hs_done", hs_done_o, 1);
      tick(); hs_req_i = 1'b0;
      ticks(G - 2);
      chk("t1_busy_gap", busy_o, 1);
      tick();
      chk("t1_busy_idle", busy_o, 0);
      chk("t1_pid_cleared", tx_pid_o, 0);
      chk("t1_nstart", start_q.size(), 1);
      if (start_q.size() == 1) begin
         chk("t1_start_cyc", start_q[0], c + 2);
         chk("t1_start_pid", pid_q[0], PidAck);
      end
      chk("t1_ndone", hs_done_q.size(), 1);
      if (hs_done_q.size() == 1) chk("t1_done_cyc", hs_done_q[0], e + 1);
      in_data_avail_i = 1'b0;

      // 2: IN packet with three bytes
      clr();
      ip = in_pids[$urandom_range(0, 1)];
      in_pid_i = ip; in_req_i = 1'b1; c = cyc;
      ticks(3);
      for (int i = 0; i < 3; i++) begin
         in_data_i = bytes[i]; in_data_avail_i = 1'b1; tx_data_get_i = 1'b1;
         #1;
         chk("t2_data", tx_data_o, bytes[i]);
         chk("t2_avail", tx_data_avail_o, 1);
         chk("t2_get", in_data_get_o, 1);
         tick(); tx_data_get_i = 1'b0;
         ticks($urandom_range(0, 2));
      end
      in_data_avail_i = 1'b0;
      pulse_end(e);
      chk("t2_in_done", in_done_o, 1);
      tick(); in_req_i = 1'b0;
      ticks(G - 1);
      chk("t2_busy_idle", busy_o, 0);
      in_data_avail_i = 1'b1; #1;
      chk("t2_idle_avail_masked", tx_data_avail_o, 0);
      in_data_avail_i = 1'b0;
      chk("t2_gets", get_cnt, 3);
      chk("t2_nstart", start_q.size(), 1);
      if (start_q.size() == 1) begin
         chk("t2_start_cyc", start_q[0], c + 2);
         chk("t2_start_pid", pid_q[0], ip);
      end
      chk("t2_ndone", in_done_q.size(), 1);
      if (in_done_q.size() == 1) chk("t2_done_cyc", in_done_q[0], e + 1);
      chk("t2_no_hs_done", hs_done_q.size(), 0);

      // 3: simultaneous requests, handshake first, DATA after the gap
      clr();
      hp = hs_pids[$urandom_range(0, 2)]; ip = in_pids[$urandom_range(0, 1)];
      hs_pid_i = hp; in_pid_i = ip; hs_req_i = 1'b1; in_req_i = 1'b1; c = cyc;
      k = $urandom_range(1, 8);
      ticks(2 + k);
      pulse_end(e);
      tick(); hs_req_i = 1'b0;
      ticks(G + 1);
      chk("t3_in_start", tx_pkt_start_o, 1);
      chk("t3_in_pid", tx_pid_o, ip);
      tick();
      pulse_end(e);
      tick(); in_req_i = 1'b0;
      ticks(G - 1);
      chk("t3_busy_idle", busy_o, 0);
      chk("t3_nstart", start_q.size(), 2);
      if (start_q.size() == 2 && hs_done_q.size() == 1) begin
         chk("t3_first_cyc", start_q[0], c + 2);
         chk("t3_first_pid", pid_q[0], hp);
         chk("t3_second_pid", pid_q[1], ip);
         chk("t3_done_to_start", start_q[1] - hs_done_q[0], G + 2);
      end
      chk("t3_in_ndone", in_done_q.size(), 1);

      // 4: watchdog
      clr();
      in_pid_i = in_pids[$urandom_range(0, 1)]; in_req_i = 1'b1; c = cyc;
      ticks(T + 3);
      chk("t4_timeout", timeout_o, 1);
      chk("t4_no_done", in_done_o, 0);
      in_req_i = 1'b0;
      tick();
      chk("t4_timeout_once", timeout_o, 0);
      ticks(G - 1);
      chk("t4_busy_idle", busy_o, 0);
      chk("t4_nto", to_q.size(), 1);
      if (to_q.size() == 1 && start_q.size() == 1) chk("t4_to_cyc", to_q[0], start_q[0] + T + 1);
      chk("t4_ndone", in_done_q.size() + hs_done_q.size(), 0);

      // 5: link reset during a byte pull
      clr();
      in_pid_i = in_pids[$urandom_range(0, 1)]; in_req_i = 1'b1;
      ticks(3);
      in_data_i = 8'($urandom) | 8'h01; in_data_avail_i = 1'b1; tx_data_get_i = 1'b1;
      link_reset_i = 1'b1; #1;
      chk("t5_get_pass", in_data_get_o, 1);
      tick();
      chk("t5_busy", busy_o, 0);
      chk("t5_pid", tx_pid_o, 0);
      chk("t5_mux", {tx_data_avail_o, tx_data_o, in_data_get_o}, 0);
      link_reset_i = 1'b0; in_req_i = 1'b0; tx_data_get_i = 1'b0; in_data_avail_i = 1'b0;
      ticks(G + 4);
      chk("t5_no_done", in_done_q.size(), 0);
      clr();
      hp = hs_pids[$urandom_range(0, 2)]; hs_pid_i = hp; hs_req_i = 1'b1;
      ticks(2);
      chk("t5_restart", tx_pkt_start_o, 1);
      chk("t5_restart_pid", tx_pid_o, hp);
      tick();
      pulse_end(e);
      chk("t5_hs_done", hs_done_o, 1);
      tick(); hs_req_i = 1'b0;

      // 6: asynchronous reset in the gap
      ticks(2);
      #2 rst_ni = 1'b0;
      #1;
      chk("t6_busy", busy_o, 0);
      chk("t6_pid", tx_pid_o, 0);
      chk("t6_pulses", {tx_pkt_start_o, hs_done_o, in_done_o, timeout_o}, 0);
      ticks(2);
      rst_ni = 1'b1;
      tick();
      clr();
      ip = in_pids[$urandom_range(0, 1)]; in_pid_i = ip; in_req_i = 1'b1; c = cyc;
      ticks(2);
      chk("t6_recover_start", tx_pkt_start_o, 1);
      chk("t6_recover_pid", tx_pid_o, ip);
      tick();
      pulse_end(e);
      chk("t6_in_done", in_done_o, 1);
      tick(); in_req_i = 1'b0;
      ticks(G - 1);
      chk("t6_busy_idle", busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
